// File: rtl/decoder_scan_pkg.sv
// -----------------------------------------------------------------------------
// decoder_scan_pkg
// Shared definitions for the decoder_4x16 scan driver: FSM state encoding,
// select-code width, terminal code values and the code-advance helper.
// -----------------------------------------------------------------------------
package decoder_scan_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] CODE_MAX = 4'hF;
    localparam logic [CODE_W-1:0] CODE_MIN = 4'h0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Next code in the sweep; wraps naturally mod 16 in both directions.
    function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                    input logic              down);
        return down ? (code - 4'd1) : (code + 4'd1);
    endfunction

endpackage

// File: rtl/decoder_scan_driver_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts the cycles a select code has been held. expire_o is high in the cycle
// where the count equals limit_i; when enabled in that cycle the counter
// returns to zero, so it never runs past the limit.
//
// Ports:
//   clk_i     rising-edge clock
//   reset_i   synchronous active-high reset
//   clear_i   force the count to zero on the next edge (priority over en_i)
//   en_i      advance the count this cycle
//   limit_i   dwell limit (code is held limit_i+1 cycles)
//   expire_o  count == limit_i
// -----------------------------------------------------------------------------
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic [DWELL_W-1:0] limit_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    assign expire_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = expire_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan_driver.sv
// -----------------------------------------------------------------------------
// decoder_scan_driver
// Drives the 4-bit select code W,X,Y,Z (W = MSB) of a decoder_4x16 through all
// 16 values, holding each code for dwell+1 cycles. Single-shot or continuous,
// up or down. All outputs come straight from registers.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      begin sweep (IDLE only)
//   stop       abort sweep (RUN only)
//   load       load load_val into the code register (IDLE only)
//   load_val   code to load, bit 3 = W
//   mode_cont  1 = continuous wrap, 0 = single sweep (captured at start)
//   dir_down   1 = decrement, 0 = increment (captured at start)
//   dwell      extra hold cycles per code (captured at start)
//   W,X,Y,Z    select code bits 3..0
//   busy       high while in RUN
//   step       pulse in the cycle after a sweep advance
//   done       pulse at end of sweep, and on each wrap in continuous mode
// -----------------------------------------------------------------------------
module decoder_scan_driver
    import decoder_scan_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int CODE_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               load,
    input  logic [CODE_W-1:0]  load_val,
    input  logic               mode_cont,
    input  logic               dir_down,
    input  logic [DWELL_W-1:0] dwell,
    output logic               W,
    output logic               X,
    output logic               Y,
    output logic               Z,
    output logic               busy,
    output logic               step,
    output logic               done
);

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q,  code_d;
    logic               step_q,  step_d;
    logic               done_q,  done_d;

    // Sweep configuration, frozen for the duration of a run.
    logic               cont_q,  cont_d;
    logic               down_q,  down_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic               tmr_clear;
    logic               tmr_en;
    logic               expire;
    logic               terminal;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (tmr_clear),
        .en_i     (tmr_en),
        .limit_i  (dwell_q),
        .expire_o (expire)
    );

    assign terminal = down_q ? (code_q == CODE_MIN) : (code_q == CODE_MAX);

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        step_d    = 1'b0;
        done_d    = 1'b0;
        cont_d    = cont_q;
        down_d    = down_q;
        dwell_d   = dwell_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    code_d = load_val;
                end
                if (start) begin
                    state_d   = S_RUN;
                    tmr_clear = 1'b1;
                    cont_d    = mode_cont;
                    down_d    = dir_down;
                    dwell_d   = dwell;
                end
            end
            S_RUN: begin
                // stop wins over a dwell expiry landing in the same cycle.
                if (stop) begin
                    state_d   = S_IDLE;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (expire) begin
                        if (terminal && !cont_q) begin
                            // Single-shot end: code stays on the terminal value.
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            code_d = next_code(code_q, down_q);
                            step_d = 1'b1;
                            done_d = terminal;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        cont_q  <= cont_d;
        down_q  <= down_d;
        dwell_q <= dwell_d;
    end

    assign W    = code_q[3];
    assign X    = code_q[2];
    assign Y    = code_q[1];
    assign Z    = code_q[0];
    assign busy = (state_q == S_RUN);
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
module tb_decoder_scan_driver;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               stop;
    logic               load;
    logic [3:0]         load_val;
    logic               mode_cont;
    logic               dir_down;
    logic [DWELL_W-1:0] dwell;
    logic               W, X, Y, Z;
    logic               busy, step, done;

    int n_cmp  = 0;
    int n_fail = 0;

    decoder_scan_driver #(
        .DWELL_W (DWELL_W),
        .CODE_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .load      (load),
        .load_val  (load_val),
        .mode_cont (mode_cont),
        .dir_down  (dir_down),
        .dwell     (dwell),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .busy      (busy),
        .step      (step),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       sp;
        logic       ld;
        logic [3:0] lv;
        logic       mc;
        logic       dd;
        logic [7:0] dw;
        logic [3:0] e_code;
        logic       e_busy;
        logic       e_step;
        logic       e_done;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic drive(input logic rst, input logic st, input logic sp, input logic ld,
                         input logic [3:0] lv, input logic mc, input logic dd,
                         input logic [7:0] dw);
        reset     = rst;
        start     = st;
        stop      = sp;
        load      = ld;
        load_val  = lv;
        mode_cont = mc;
        dir_down  = dd;
        dwell     = dw;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_code, input logic e_busy,
                         input logic e_step, input logic e_done);
        logic [6:0] act;
        logic [6:0] exp_v;
        act   = {W, X, Y, Z, busy, step, done};
        exp_v = {e_code, e_busy, e_step, e_done};
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got code=%h busy=%b step=%b done=%b, expected code=%h busy=%b step=%b done=%b",
                     name, act[6:3], act[2], act[1], act[0], e_code, e_busy, e_step, e_done);
        end
    endtask

    initial begin
        int steps;

        // rst st sp ld lv mc dd dw | code busy step done
        // Load+start together, then stop.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 8'd0, 4'h3, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h4, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h4, 1'b0, 1'b0, 1'b0};
        // Stop colliding with dwell expiry at code 5, dwell=1.
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 8'd1, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 4'h4, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 4'h5, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 4'h5, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, 4'h5, 1'b0, 1'b0, 1'b0};
        // Reset mid-sweep; start/load/dwell in RUN ignored.
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 8'd0, 4'h6, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b1, 1'b1, 8'd5, 4'h7, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 1'b0, 1'b0};
        // Single-shot up started on the terminal code.
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 8'd0, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'hF, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 4'hF, 1'b0, 1'b0, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        tick();
        tick();
        check("reset", 4'h0, 1'b0, 1'b0, 1'b0);

        // Test 1: single-shot up, dwell 0, from 0.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0);
        tick();
        check("t1_load", 4'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        tick();
        check("t1_first", 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        steps = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            if (step === 1'b1) steps++;
            check($sformatf("t1_code%0d", i), 4'(i), 1'b1, 1'b1, 1'b0);
        end
        tick();
        if (step === 1'b1) steps++;
        check("t1_done", 4'hF, 1'b0, 1'b0, 1'b1);
        tick();
        if (step === 1'b1) steps++;
        check("t1_after", 4'hF, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (steps != 15) begin
            n_fail++;
            $display("FAIL t1_step_count: got %0d, expected 15", steps);
        end

        // Test 2: single-shot down from A, dwell 2.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 8'd2);
        tick();
        check("t2_first", 4'hA, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        for (int c = 10; c >= 0; c--) begin
            for (int k = 0; k < 3; k++) begin
                if (!(c == 10 && k == 0)) begin
                    tick();
                    check($sformatf("t2_c%0d_k%0d", c, k), 4'(c), 1'b1,
                          (k == 0) ? 1'b1 : 1'b0, 1'b0);
                end
            end
        end
        tick();
        check("t2_done", 4'h0, 1'b0, 1'b0, 1'b1);
        tick();
        check("t2_nowrap", 4'h0, 1'b0, 1'b0, 1'b0);

        // Test 3: continuous up from E; mode input dropped after start.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 8'd0);
        tick();
        check("t3_E", 4'hE, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 8'd3);
        tick();
        check("t3_F", 4'hF, 1'b1, 1'b1, 1'b0);
        tick();
        check("t3_wrap0", 4'h0, 1'b1, 1'b1, 1'b1);
        tick();
        check("t3_1", 4'h1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        tick();
        check("t3_stop", 4'h1, 1'b0, 1'b0, 1'b0);

        // Continuous down wrap 0 -> F.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 8'd0);
        tick();
        check("t3d_0", 4'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0);
        tick();
        check("t3d_wrapF", 4'hF, 1'b1, 1'b1, 1'b1);
        tick();
        check("t3d_E", 4'hE, 1'b1, 1'b1, 1'b0);

        // Table: load+start, stop/expiry collision, reset mid-sweep, terminal start.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].sp, vecs[i].ld, vecs[i].lv,
                  vecs[i].mc, vecs[i].dd, vecs[i].dw);
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_code, vecs[i].e_busy,
                  vecs[i].e_step, vecs[i].e_done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
